// File: rtl/banked_main_mem_pkg.sv
// Shared memory-system parameters and address helpers.
// The cache controller imports this package too, so the constants live here only.
package mem_params;

    localparam int NUM_BANKS      = 4;
    localparam int ROW_BITS       = 13;
    localparam int BANK_OCCUPANCY = 4;
    localparam int READ_LATENCY   = 2;

    localparam int BANK_BITS   = $clog2(NUM_BANKS);
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int WORD_ADDR_W = ROW_BITS + BANK_BITS;
    localparam int CTR_W       = $clog2(BANK_OCCUPANCY + 1);

    typedef logic [DATA_W-1:0] word_t;

    // Byte address split into its fields: row, bank, and the byte-select bit.
    typedef struct packed {
        logic [ROW_BITS-1:0]  row;
        logic [BANK_BITS-1:0] bank;
        logic                 byte_sel;
    } byte_addr_t;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic  vld;
        word_t data;
    } rd_stage_t;

    // Storage word address is {row, bank}.
    function automatic logic [WORD_ADDR_W-1:0] word_addr(input byte_addr_t a);
        return {a.row, a.bank};
    endfunction

endpackage

// File: rtl/banked_main_mem_if.sv
// Request/response bus between a requester and the banked main memory.
interface banked_main_mem_if;
    import mem_params::*;

    logic                 rd;
    logic                 wr;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic [DATA_W-1:0]    data_out;
    logic                 data_valid;
    logic                 stall;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

    modport master (
        output rd, wr, addr, data_in,
        input  data_out, data_valid, stall, busy, err
    );

    modport slave (
        input  rd, wr, addr, data_in,
        output data_out, data_valid, stall, busy, err
    );

endinterface

// File: rtl/bank_busy_ctr.sv
// Per-bank occupancy counter: loaded on accept, counts down to zero, busy while nonzero.
module bank_busy_ctr
    import mem_params::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_busy
);

    logic [CTR_W-1:0] w_cnt_d;
    logic [CTR_W-1:0] r_cnt;

    // Next count: reload on accept, otherwise step down and hold at zero.
    always_comb begin
        // NOTE: default first so every path assigns w_cnt_d and no latch is inferred.
        w_cnt_d = r_cnt;
        if (i_load)
            w_cnt_d = CTR_W'(BANK_OCCUPANCY);
        else if (r_cnt != '0)
            w_cnt_d = r_cnt - CTR_W'(1);
    end

    dff #(.WIDTH(CTR_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .i_d (w_cnt_d),
        .o_q (r_cnt)
    );

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/dff.sv
// Basic register primitive with synchronous active-high reset.
module dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture D each rising edge, or the reset value when rst is high.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (rst) r_q <= RESET_VAL;
        else     r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/banked_main_mem.sv
// Four-bank main memory: one request per cycle, per-bank occupancy,
// fixed two-cycle read return.
module banked_main_mem
    import mem_params::*;
(
    input  logic              clk,
    input  logic              rst,
    banked_main_mem_if.slave  bus
);

    byte_addr_t             w_req;
    logic [WORD_ADDR_W-1:0] w_waddr;
    logic                   w_legal;
    logic                   w_err;
    logic                   w_stall;
    logic                   w_accept;
    logic                   w_accept_rd;
    logic                   w_accept_wr;
    logic [NUM_BANKS-1:0]   w_busy;
    logic [NUM_BANKS-1:0]   w_load;

    // Stage 0 is the accepted read this cycle; stage READ_LATENCY drives the outputs.
    rd_stage_t [READ_LATENCY:0] w_pipe;

    word_t r_mem [0:(1 << WORD_ADDR_W)-1];

    assign w_req   = byte_addr_t'(bus.addr);
    assign w_waddr = word_addr(w_req);

    // Decode legality, bank conflict and acceptance of the current request.
    always_comb begin
        w_err       = 1'b0;
        w_legal     = 1'b0;
        w_stall     = 1'b0;
        w_accept    = 1'b0;
        w_accept_rd = 1'b0;
        w_accept_wr = 1'b0;
        w_load      = '0;

        w_err       = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & w_req.byte_sel);
        w_legal     = (bus.rd ^ bus.wr) & ~w_req.byte_sel;
        // Illegal requests never stall; only a legal one hitting a busy bank does.
        w_stall     = w_legal & w_busy[w_req.bank];
        w_accept    = w_legal & ~w_stall & ~rst;
        w_accept_rd = w_accept & bus.rd;
        w_accept_wr = w_accept & bus.wr;
        w_load[w_req.bank] = w_accept;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_busy_ctr u_ctr (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[b]),
            .o_busy (w_busy[b])
        );
    end

    // Write port: an accepted write lands at the edge ending its cycle.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; contents survive rst and only accepted writes change them.
        if (w_accept_wr)
            r_mem[w_waddr] <= bus.data_in;
    end

    // Read data is sampled in the accept cycle, then carried through the pipeline.
    assign w_pipe[0] = rd_stage_t'({w_accept_rd, (w_accept_rd ? r_mem[w_waddr] : word_t'(0))});

    for (genvar s = 0; s < READ_LATENCY; s++) begin : g_rd_pipe
        dff #(.WIDTH($bits(rd_stage_t))) u_stage (
            .clk (clk),
            .rst (rst),
            .i_d (w_pipe[s]),
            .o_q (w_pipe[s+1])
        );
    end

    assign bus.data_valid = w_pipe[READ_LATENCY].vld;
    assign bus.data_out   = w_pipe[READ_LATENCY].vld ? w_pipe[READ_LATENCY].data : '0;
    assign bus.stall      = w_stall;
    assign bus.busy       = w_busy;
    assign bus.err        = w_err;

endmodule

// File: tb/tb_banked_main_mem.sv
// Directed self-checking bench for banked_main_mem.
module tb_banked_main_mem;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    banked_main_mem_if bus ();

    banked_main_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic i_rd, input logic i_wr,
                          input logic [15:0] i_addr, input logic [15:0] i_data);
        bus.rd      = i_rd;
        bus.wr      = i_wr;
        bus.addr    = i_addr;
        bus.data_in = i_data;
    endtask

    // Present a request for one cycle; returns mid-cycle so outputs can be checked.
    task automatic step(input logic i_rd, input logic i_wr,
                        input logic [15:0] i_addr, input logic [15:0] i_data);
        @(posedge clk);
        #1;
        set_in(i_rd, i_wr, i_addr, i_data);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic check_out(input string tag, input logic exp_dv, input logic [15:0] exp_do);
        check({tag, ".dv"}, 32'(bus.data_valid), 32'(exp_dv));
        check({tag, ".do"}, 32'(bus.data_out), 32'(exp_do));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst.busy", 32'(bus.busy), 32'h0);
        check("rst.stall", 32'(bus.stall), 32'h0);
        check("rst.err", 32'(bus.err), 32'h0);
        check_out("rst", 1'b0, 16'h0000);

        // Preload: back-to-back writes to banks 0..3 are all accepted.
        step(1'b0, 1'b1, 16'h0000, 16'hA000); check("pre0.stall", 32'(bus.stall), 32'h0);
        step(1'b0, 1'b1, 16'h0002, 16'hA002); check("pre1.stall", 32'(bus.stall), 32'h0);
        step(1'b0, 1'b1, 16'h0004, 16'hA004); check("pre2.stall", 32'(bus.stall), 32'h0);
        step(1'b0, 1'b1, 16'h0006, 16'hA006); check("pre3.stall", 32'(bus.stall), 32'h0);
        check("pre3.busy", 32'(bus.busy), 32'h7);
        idle(5);
        step(1'b0, 1'b1, 16'h000A, 16'hB00A); check("pre4.stall", 32'(bus.stall), 32'h0);
        step(1'b0, 1'b1, 16'h0040, 16'hC040); check("pre5.stall", 32'(bus.stall), 32'h0);
        idle(5);

        // Write then read bank 0, occupancy window T+1..T+4
        step(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        check("w1.stall", 32'(bus.stall), 32'h0);
        check("w1.err", 32'(bus.err), 32'h0);
        check("w1.busy_t0", 32'(bus.busy), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            check($sformatf("w1.busy_t%0d", i), 32'(bus.busy), 32'h1);
        end
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        check("r1.busy_t5", 32'(bus.busy), 32'h0);
        check("r1.stall", 32'(bus.stall), 32'h0);
        idle(1); check_out("r1.t6", 1'b0, 16'h0000);
        idle(1); check_out("r1.t7", 1'b1, 16'hBEEF);
        idle(1); check_out("r1.t8", 1'b0, 16'h0000);
        idle(2);

        // Bank 1 conflict: stalled at T+1 and T+4, accepted at T+5
        step(1'b1, 1'b0, 16'h0002, 16'h0000); check("b1.t0.stall", 32'(bus.stall), 32'h0);
        step(1'b1, 1'b0, 16'h000A, 16'h0000);
        check("b1.t1.stall", 32'(bus.stall), 32'h1);
        check("b1.t1.busy", 32'(bus.busy), 32'h2);
        check("b1.t1.err", 32'(bus.err), 32'h0);
        idle(1); check_out("b1.t2", 1'b1, 16'hA002);
        idle(1); check_out("b1.t3", 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h000A, 16'h0000); check("b1.t4.stall", 32'(bus.stall), 32'h1);
        step(1'b1, 1'b0, 16'h000A, 16'h0000);
        check("b1.t5.stall", 32'(bus.stall), 32'h0);
        check("b1.t5.busy", 32'(bus.busy), 32'h0);
        idle(1); check_out("b1.t6", 1'b0, 16'h0000);
        idle(1); check_out("b1.t7", 1'b1, 16'hB00A);
        idle(3);

        // Streaming reads across all four banks
        step(1'b1, 1'b0, 16'h0000, 16'h0000); check("s.t0.stall", 32'(bus.stall), 32'h0);
        step(1'b1, 1'b0, 16'h0002, 16'h0000); check("s.t1.stall", 32'(bus.stall), 32'h0);
        step(1'b1, 1'b0, 16'h0004, 16'h0000); check("s.t2.stall", 32'(bus.stall), 32'h0);
        check_out("s.t2", 1'b1, 16'hA000);
        step(1'b1, 1'b0, 16'h0006, 16'h0000); check("s.t3.stall", 32'(bus.stall), 32'h0);
        check_out("s.t3", 1'b1, 16'hA002);
        idle(1); check("s.t4.busy", 32'(bus.busy), 32'hF);
        check_out("s.t4", 1'b1, 16'hA004);
        idle(1); check_out("s.t5", 1'b1, 16'hA006);
        idle(1); check_out("s.t6", 1'b0, 16'h0000);
        check("s.t6.err", 32'(bus.err), 32'h0);
        check("s.t6.stall", 32'(bus.stall), 32'h0);
        idle(2);

        // Illegal requests
        step(1'b1, 1'b1, 16'h0020, 16'h5555);
        check("e.rdwr.err", 32'(bus.err), 32'h1);
        check("e.rdwr.stall", 32'(bus.stall), 32'h0);
        check("e.rdwr.busy", 32'(bus.busy), 32'h0);
        step(1'b1, 1'b0, 16'h0021, 16'h0000);
        check("e.odd.err", 32'(bus.err), 32'h1);
        check("e.odd.stall", 32'(bus.stall), 32'h0);
        check("e.odd.busy", 32'(bus.busy), 32'h0);
        idle(1); check_out("e.t2", 1'b0, 16'h0000);
        check("e.t2.busy", 32'(bus.busy), 32'h0);
        idle(1); check_out("e.t3", 1'b0, 16'h0000);

        // Reset during an in-flight read, with a write presented under reset
        step(1'b1, 1'b0, 16'h0004, 16'h0000); check("rr.t0.stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(1'b0, 1'b1, 16'h0040, 16'hDEAD);
        @(negedge clk);
        check("rr.t1.busy", 32'(bus.busy), 32'h4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("rr.t2.busy", 32'(bus.busy), 32'h0);
        check_out("rr.t2", 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        check("rr.t3.stall", 32'(bus.stall), 32'h0);
        check_out("rr.t3", 1'b0, 16'h0000);
        idle(1); check_out("rr.t4", 1'b0, 16'h0000);
        idle(1); check_out("rr.t5", 1'b1, 16'hC040);
        idle(3);

        // Top row, bank 3 boundary; stall on the counter's last cycle
        step(1'b0, 1'b1, 16'hFFFE, 16'h1234);
        check("tb.t0.stall", 32'(bus.stall), 32'h0);
        check("tb.t0.err", 32'(bus.err), 32'h0);
        idle(1); check("tb.t1.busy", 32'(bus.busy), 32'h8);
        idle(2);
        step(1'b1, 1'b0, 16'hFFFE, 16'h0000);
        check("tb.t4.stall", 32'(bus.stall), 32'h1);
        check("tb.t4.busy", 32'(bus.busy), 32'h8);
        step(1'b1, 1'b0, 16'hFFFE, 16'h0000);
        check("tb.t5.stall", 32'(bus.stall), 32'h0);
        check("tb.t5.busy", 32'(bus.busy), 32'h0);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        check("tb.t6.stall", 32'(bus.stall), 32'h0);
        check_out("tb.t6", 1'b0, 16'h0000);
        idle(1); check_out("tb.t7", 1'b1, 16'h1234);
        idle(1); check_out("tb.t8", 1'b1, 16'hBEEF);
        idle(1); check_out("tb.t9", 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/banked_main_mem.md
BANKED_MAIN_MEM -- requirements
Module: banked_main_mem

Interface
REQ-001 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have input rd, 1 bit: read request this cycle.
REQ-004 The block SHALL have input wr, 1 bit: write request this cycle.
REQ-005 The block SHALL have input addr, 16 bits: byte address, where addr[2:1] is the bank and addr[15:3] is the row.
REQ-006 The block SHALL have input data_in, 16 bits: write data.
REQ-007 The block SHALL have output data_out, 16 bits: read data, valid only while data_valid=1, otherwise 0.
REQ-008 The block SHALL have output data_valid, 1 bit: data_out carries the result of an accepted read.
REQ-009 The block SHALL have output stall, 1 bit: combinational; the current request is refused.
REQ-010 The block SHALL have output busy, 4 bits: bit b set while bank b is occupied.
REQ-011 The block SHALL have output err, 1 bit: the current request is illegal and refused.

Function
REQ-012 Storage SHALL be 4 banks x 8192 rows x 16 bits, with word address {row, bank}.
REQ-013 A request is legal when exactly one of rd/wr is set and addr[0]=0; err SHALL be 1 in any cycle with rd&wr, or with (rd|wr)&addr[0].
REQ-014 stall SHALL be 1 in a cycle with a legal request whose bank b has busy[b]=1; otherwise stall SHALL be 0.
REQ-015 A request is accepted in cycle T iff it is legal, stall=0 and rst=0; refused requests SHALL have no side effect, and the requester SHALL re-present them.
REQ-016 Accept at T SHALL load bank b's occupancy counter with 4, so that busy[b]=1 in cycles T+1..T+4 and busy[b]=0 in T+5 absent a new accept; busy[b] SHALL equal (counter[b]!=0).
REQ-017 Counters SHALL decrement by 1 per cycle while nonzero, SHALL saturate at 0, and SHALL be independent per bank.
REQ-018 An accepted write SHALL update the addressed word at the edge ending T.
REQ-019 An accepted read SHALL present data_out with data_valid=1 in exactly cycle T+2, for one cycle.
REQ-020 The read pipeline SHALL be 2 stages deep and SHALL carry up to two reads in flight to different banks.
REQ-021 The block SHALL accept one request per cycle to distinct non-busy banks, which gives 4 back-to-back accesses to banks 0,1,2,3 with a read result every cycle.
REQ-022 A request issued in the same cycle that busy[b] is on its last cycle (counter=1) SHALL be stalled; the same request issued one cycle later SHALL be accepted.
REQ-023 A read to a word written by an earlier accepted write SHALL return the new value.
REQ-024 rd=wr=0 SHALL give stall=0 and err=0, with no state change except counter decrement.

Reset
REQ-025 rst=1 at an edge SHALL clear all bank counters (busy=0) and both read pipeline stages (data_valid=0, data_out=0).
REQ-026 A request present in the same cycle as rst=1 SHALL NOT be accepted, and storage SHALL NOT be written.
REQ-027 A read in flight when rst is asserted SHALL be discarded, and no data_valid pulse SHALL follow.
REQ-028 Storage contents SHALL be unaffected by reset; after reset, storage SHALL hold previously written values.

Structure
REQ-029 Constants BANK_OCCUPANCY=4, READ_LATENCY=2, NUM_BANKS=4 and ROW_BITS=13 SHALL reside in shared package mem_params, which the cache controller also uses.
REQ-030 The per-bank occupancy counter (load 4, decrement, busy flag) SHALL be sub-module bank_busy_ctr, instantiated 4 times.
REQ-031 All flops SHALL be built from the team's dff primitive; storage SHALL be a behavioural array.

Verification
REQ-032 The bench SHALL cover: wr addr=0x0010, data 0xBEEF at T; rd addr=0x0010 at T+5 -> data_out=0xBEEF, data_valid=1 at T+7; busy[0]=1 for T+1..T+4.
REQ-033 The bench SHALL cover: rd addr=0x0002 at T, then rd addr=0x000A at T+1 and T+4 -> stall=1 at both (busy[1]); rd at T+5 -> accepted, data at T+7.
REQ-034 The bench SHALL cover: reads to 0x0000, 0x0002, 0x0004, 0x0006 in cycles T..T+3 -> no stall; data_valid=1 in T+2..T+5 with data in bank order; busy=4'b1111 at T+4.
REQ-035 The bench SHALL cover: rd=wr=1 at addr 0x0020 -> err=1, stall=0, busy unchanged; rd addr=0x0021 -> err=1, no data_valid at T+2.
REQ-036 The bench SHALL cover: rd accepted at T, rst=1 at T+1 -> busy=0 and data_valid=0 at T+2; wr at addr 0x0040 with rst=1 -> subsequent read returns the prior value.
REQ-037 The bench SHALL cover: after reset, wr 0x1234 to 0xFFFE -> read at the legal later cycle returns 0x1234, which checks the top-row/bank-3 boundary.
